// File: rtl/mxv_packet_parser_if.sv
// mxv_packet_parser_if: byte stream in from the UART receiver, element stream and control out to MxV.
// master: UART/bench side (drives rx_*). slave: parser side (drives mat_size, elem_*, start, frame_err, busy).
interface mxv_packet_parser_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [3:0] mat_size;
  logic [7:0] elem_data;
  logic       elem_valid;
  logic       elem_sel;
  logic [2:0] elem_row;
  logic [2:0] elem_col;
  logic       start;
  logic       frame_err;
  logic       busy;
  modport master (output rx_data, rx_done,
                  input  mat_size, elem_data, elem_valid, elem_sel, elem_row, elem_col, start, frame_err, busy);
  modport slave  (input  rx_data, rx_done,
                  output mat_size, elem_data, elem_valid, elem_sel, elem_row, elem_col, start, frame_err, busy);
endinterface

// File: rtl/mxv_packet_parser.sv
// mxv_packet_parser: validates length-delimited command frames and forwards matrix/vector elements to MxV.
// Ports: clk, rst (async, active-high), bus (slave): rx_data/rx_done in; mat_size, elem_data/valid/sel/row/col,
// start, frame_err, busy out. Define PKT_CHECKSUM_EN to require an XOR checksum byte before the trailer.
module mxv_packet_parser #(
  parameter int         MAX_N          = 8,
  parameter logic [7:0] START_BYTE     = 8'hFE,
  parameter logic [7:0] END_BYTE       = 8'hEF,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic clk,
  input logic rst,
  mxv_packet_parser_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LEN, CMD, PAYLOAD, CHK, END} state_t;
  state_t state, state_n;
  logic [7:0] len, len_n, cmd, cmd_n, cnt, cnt_n, pend, pend_n, nn, data_n;
  logic [2:0] r, r_n, c, c_n, row_n, col_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0] size_n;
  logic ev_n, sel_n, start_n, err_n, ok, adv_row;
`ifdef PKT_CHECKSUM_EN
  logic [7:0] chk, chk_n;
`endif
  assign bus.busy = state != IDLE;
  always_comb begin
    nn = 8'(bus.mat_size) * 8'(bus.mat_size);
    ok = (bus.rx_data == 8'h01 && len == 8'd2) ||
         (bus.rx_data == 8'h03 && bus.mat_size != 4'd0 && len == nn + 8'd1) ||
         (bus.rx_data == 8'h04 && bus.mat_size != 4'd0 && len == 8'(bus.mat_size) + 8'd1);
    // vectors advance the row every byte; matrices only when the column wraps
    adv_row = cmd == 8'h04 || {1'b0, c} == bus.mat_size - 4'd1;
    state_n = state;
    len_n = len;
    cmd_n = cmd;
    cnt_n = cnt;
    pend_n = pend;
    r_n = r;
    c_n = c;
    size_n = bus.mat_size;
    data_n = bus.elem_data;
    sel_n = bus.elem_sel;
    row_n = bus.elem_row;
    col_n = bus.elem_col;
    ev_n = 1'b0;
    start_n = 1'b0;
    err_n = 1'b0;
    tmr_n = (state == IDLE || bus.rx_done) ? '0 : tmr + 1'b1;
`ifdef PKT_CHECKSUM_EN
    chk_n = chk;
`endif
    if (bus.rx_done) begin
      case (state)
        IDLE: state_n = bus.rx_data == START_BYTE ? LEN : IDLE;
        LEN: begin
          len_n = bus.rx_data;
`ifdef PKT_CHECKSUM_EN
          chk_n = bus.rx_data;
`endif
          state_n = CMD;
        end
        CMD: begin
          cmd_n = bus.rx_data;
`ifdef PKT_CHECKSUM_EN
          chk_n = chk ^ bus.rx_data;
`endif
          cnt_n = len - 8'd1;
          r_n = 3'd0;
          c_n = 3'd0;
          err_n = !ok;
          state_n = !ok ? IDLE : len == 8'd1 ? END : PAYLOAD;
        end
        PAYLOAD: begin
          cnt_n = cnt - 8'd1;
`ifdef PKT_CHECKSUM_EN
          chk_n = chk ^ bus.rx_data;
          state_n = cnt == 8'd1 ? CHK : PAYLOAD;
`else
          state_n = cnt == 8'd1 ? END : PAYLOAD;
`endif
          if (cmd == 8'h01) pend_n = bus.rx_data;
          else begin
            ev_n = 1'b1;
            data_n = bus.rx_data;
            sel_n = cmd == 8'h04;
            row_n = r;
            col_n = c;
            r_n = adv_row ? r + 3'd1 : r;
            c_n = adv_row ? 3'd0 : c + 3'd1;
          end
        end
`ifdef PKT_CHECKSUM_EN
        CHK: begin
          err_n = bus.rx_data != chk;
          state_n = bus.rx_data == chk ? END : IDLE;
        end
`endif
        END: begin
          state_n = IDLE;
          if (bus.rx_data != END_BYTE) err_n = 1'b1;
          else if (cmd == 8'h01) begin
            if (pend != 8'd0 && pend <= 8'(MAX_N)) size_n = pend[3:0];
            else err_n = 1'b1;
          end
          else start_n = cmd == 8'h04;
        end
        default: state_n = IDLE;
      endcase
    end
    else if (state != IDLE && tmr == TW'(TIMEOUT_CYCLES - 1)) begin
      err_n = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      cmd <= '0;
      cnt <= '0;
      pend <= '0;
      r <= '0;
      c <= '0;
      tmr <= '0;
`ifdef PKT_CHECKSUM_EN
      chk <= '0;
`endif
      bus.mat_size <= '0;
      bus.elem_data <= '0;
      bus.elem_valid <= 1'b0;
      bus.elem_sel <= 1'b0;
      bus.elem_row <= '0;
      bus.elem_col <= '0;
      bus.start <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      cmd <= cmd_n;
      cnt <= cnt_n;
      pend <= pend_n;
      r <= r_n;
      c <= c_n;
      tmr <= tmr_n;
`ifdef PKT_CHECKSUM_EN
      chk <= chk_n;
`endif
      bus.mat_size <= size_n;
      bus.elem_data <= data_n;
      bus.elem_valid <= ev_n;
      bus.elem_sel <= sel_n;
      bus.elem_row <= row_n;
      bus.elem_col <= col_n;
      bus.start <= start_n;
      bus.frame_err <= err_n;
    end
  end
endmodule

// File: tb/tb_mxv_packet_parser.sv
// tb_mxv_packet_parser: table vectors, hand-written corner sequences and random frames vs. a frame-level model.
module tb_mxv_packet_parser;
  localparam int T = 40;
`ifdef PKT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b[8];
    int n;
    logic [7:0] e;
    int size, ev, st, er;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mxv_packet_parser_if bus();
  mxv_packet_parser #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, msize = 0, n_ev = 0, n_st = 0, n_er = 0;
  vec_t tbl[8];
  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_zero(input string p);
    check({p, " mat_size"}, bus.mat_size, 0);
    check({p, " elem_data"}, bus.elem_data, 0);
    check({p, " elem_valid"}, bus.elem_valid, 0);
    check({p, " elem_sel"}, bus.elem_sel, 0);
    check({p, " elem_row"}, bus.elem_row, 0);
    check({p, " elem_col"}, bus.elem_col, 0);
    check({p, " start"}, bus.start, 0);
    check({p, " frame_err"}, bus.frame_err, 0);
    check({p, " busy"}, bus.busy, 0);
  endtask
  // entered on a falling edge; returns on the next falling edge with the byte's results visible
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    n_ev += int'(bus.elem_valid);
    n_st += int'(bus.start);
    n_er += int'(bus.frame_err);
  endtask
  function automatic bq_t build(input bq_t h, input logic [7:0] e);
    bq_t q = h;
    logic [7:0] x = 8'h00;
    for (int i = 1; i < h.size(); i++) x ^= h[i];
    if (CK == 1) q.push_back(x);
    q.push_back(e);
    return q;
  endfunction
  // frame-level model: byte positions relative to the header decide what each byte must produce
  task automatic run_frame(input bq_t q);
    int L, C, N, k, eev, est, eer, erow, ecol;
    bit ok, dead;
    logic [7:0] x;
    L = q[1];
    C = q[2];
    N = msize;
    dead = 0;
    x = 8'h00;
    ok = (C == 1 && L == 2) || (C == 3 && N != 0 && L == N * N + 1) || (C == 4 && N != 0 && L == N + 1);
    for (int i = 0; i < q.size(); i++) begin
      eev = 0; est = 0; eer = 0; erow = 0; ecol = 0;
      send(q[i]);
      if (!dead) begin
        if (i == 2 && !ok) begin
          eer = 1;
          dead = 1;
        end else if (i >= 3 && i <= L + 1) begin
          if (C != 1) begin
            eev = 1;
            k = i - 3;
            erow = C == 4 ? k : k / N;
            ecol = C == 4 ? 0 : k % N;
          end
        end else if (CK == 1 && i == L + 2) begin
          if (q[i] != x) begin
            eer = 1;
            dead = 1;
          end
        end else if (i == L + 2 + CK) begin
          dead = 1;
          if (q[i] != 8'hEF) eer = 1;
          else if (C == 1 && q[3] >= 1 && q[3] <= 8) msize = q[3];
          else if (C == 1) eer = 1;
          else est = int'(C == 4);
        end
      end
      if (i >= 1 && i <= L + 1) x ^= q[i];
      check("elem_valid", bus.elem_valid, eev);
      check("start", bus.start, est);
      check("frame_err", bus.frame_err, eer);
      check("mat_size", bus.mat_size, msize);
      check("busy", bus.busy, int'(!dead));
      if (eev == 1) begin
        check("elem_sel", bus.elem_sel, int'(C == 4));
        check("elem_row", bus.elem_row, erow);
        check("elem_col", bus.elem_col, ecol);
        check("elem_data", bus.elem_data, q[i]);
      end
    end
  endtask
  initial begin
    bq_t h;
    int j, t, n, ln;
    tbl[0] = '{'{8'hFE, 8'h02, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'hEF, 3, 0, 0, 0};
    tbl[1] = '{'{8'hFE, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'hEF, 2, 0, 0, 0};
    tbl[2] = '{'{8'hFE, 8'h05, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00}, 7, 8'hEF, 2, 4, 0, 0};
    tbl[3] = '{'{8'hFE, 8'h03, 8'h04, 8'hFE, 8'hEF, 8'h00, 8'h00, 8'h00}, 5, 8'hEF, 2, 2, 1, 0};
    tbl[4] = '{'{8'hFE, 8'h04, 8'h04, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00}, 6, 8'hEF, 2, 0, 0, 1};
    tbl[5] = '{'{8'hFE, 8'h02, 8'h01, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'hEF, 2, 0, 0, 1};
    tbl[6] = '{'{8'hFE, 8'h03, 8'h04, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00}, 5, 8'h55, 2, 2, 0, 1};
    tbl[7] = '{'{8'hFE, 8'h02, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'hEF, 2, 0, 0, 1};
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    foreach (tbl[i]) begin
      h = {};
      for (int b = 0; b < tbl[i].n; b++) h.push_back(tbl[i].b[b]);
      n_ev = 0; n_st = 0; n_er = 0;
      run_frame(build(h, tbl[i].e));
      check($sformatf("tbl%0d mat_size", i), bus.mat_size, tbl[i].size);
      check($sformatf("tbl%0d elem count", i), n_ev, tbl[i].ev);
      check($sformatf("tbl%0d start count", i), n_st, tbl[i].st);
      check($sformatf("tbl%0d err count", i), n_er, tbl[i].er);
    end
    foreach (tbl[0].b[i]) if (i < 3) begin
      send(8'h12 + 8'(i));
      check("idle junk err", bus.frame_err, 0);
      check("idle junk busy", bus.busy, 0);
    end
    send(8'hFE);
    send(8'h02);
    j = 0;
    while (j < T + 5 && !bus.frame_err) begin
      @(negedge clk);
      j++;
    end
    check("timeout cycle", j, T);
    check("timeout busy", bus.busy, 0);
    check("timeout mat_size", bus.mat_size, 2);
    send(8'hFE);
    send(8'h02);
    repeat (T - 1) @(negedge clk);
    check("pre-expiry err", bus.frame_err, 0);
    send(8'h01);
    check("coincide err", bus.frame_err, 0);
    check("coincide busy", bus.busy, 1);
    send(8'h04);
    if (CK == 1) send(8'h07);
    send(8'hEF);
    msize = 4;
    check("coincide mat_size", bus.mat_size, 4);
    check("coincide tail err", bus.frame_err, 0);
    run_frame(build('{8'hFE, 8'h02, 8'h01, 8'h02}, 8'hEF));
    send(8'hFE);
    send(8'h03);
    send(8'h04);
    send(8'h0A);
    check("pre-reset elem_valid", bus.elem_valid, 1);
    #2 rst = 1'b1;
    #1 check_zero("mid-frame reset");
    @(negedge clk);
    rst = 1'b0;
    msize = 0;
    run_frame(build('{8'hFE, 8'h03, 8'h04, 8'h01, 8'h02}, 8'hEF));
    run_frame(build('{8'hFE, 8'h02, 8'h01, 8'h05}, 8'hEF));
    for (int it = 0; it < 60; it++) begin
      t = $urandom_range(0, 6);
      if (msize == 0 && t >= 1 && t <= 3) t = 0;
      n = msize;
      h = {};
      case (t)
        0: run_frame(build('{8'hFE, 8'h02, 8'h01, 8'($urandom_range(0, 10))}, 8'hEF));
        1, 2, 3: begin
          ln = t == 1 ? n * n + 1 : n + 1;
          h = '{8'hFE, 8'(ln), t == 1 ? 8'h03 : 8'h04};
          for (int b = 1; b < ln; b++) h.push_back(8'($urandom));
          run_frame(build(h, t == 3 ? 8'($urandom_range(0, 8'hEE)) : 8'hEF));
        end
        4: run_frame('{8'hFE, 8'($urandom_range(0, 70)), 8'($urandom_range(5, 255))});
        5: run_frame('{8'hFE, 8'(n + 2), 8'h04});
        default: begin
          repeat ($urandom_range(1, 3)) begin
            send(8'($urandom_range(0, 8'hFD)));
            check("rand junk err", bus.frame_err, 0);
            check("rand junk valid", bus.elem_valid, 0);
          end
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mxv_packet_parser.md
# mxv_packet_parser

Byte-level frame parser between the UART receiver and the MxV engine. Consumes received bytes (`rx_data` with one-cycle `rx_done` strobe), validates a length-delimited command frame, and forwards matrix/vector elements with row/column coordinates. Also holds the configured matrix size and issues a single start pulse to MxV once a complete vector frame is validated. Flags malformed or stalled frames with an error pulse.

## Interface
- `MAX_N`, 8: largest matrix dimension accepted (N in 1..MAX_N)
- `START_BYTE`, 8'hFE: frame header
- `END_BYTE`, 8'hEF: frame trailer
- `TIMEOUT_CYCLES`, 100000: idle clocks tolerated between bytes inside a frame
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset; asynchronous, active-high
- `rx_data`  in  8  byte from UART receiver, valid when `rx_done`=1
- `rx_done`  in  1  one-cycle strobe per received byte
- `mat_size`  out  4  configured N; 0 = unconfigured
- `elem_data`  out  8  forwarded element byte
- `elem_valid`  out  1  one-cycle strobe qualifying `elem_data`/`elem_sel`/`elem_row`/`elem_col`
- `elem_sel`  out  1  0 = matrix element, 1 = vector element
- `elem_row`  out  3  row index (vector: element index)
- `elem_col`  out  3  column index (vector: 0)
- `start`  out  1  one-cycle pulse: vector frame accepted, MxV may compute
- `frame_err`  out  1  one-cycle pulse on any rejected frame
- `busy`  out  1  1 whenever FSM is not in IDLE

## Operation
- Frame: `START_BYTE`, L, CMD, payload (L-1 bytes), [checksum], `END_BYTE`. L counts CMD plus payload.
- Commands: 0x01 set size (L=2, payload N); 0x03 load matrix (L=1+N·N); 0x04 load vector (L=1+N).
- FSM states: IDLE, LEN, CMD, PAYLOAD, CHK (macro only), END. Advances only on `rx_done`.
- IDLE: bytes other than `START_BYTE` ignored silently. `START_BYTE` -> LEN.
- LEN: latch L -> CMD.
- CMD: validate. Unknown CMD, L mismatch for current `mat_size`, or CMD 0x03/0x04 with `mat_size`=0 -> `frame_err`, IDLE. Otherwise load remaining-byte counter = L-1 -> PAYLOAD (or END if L-1=0, never legal for defined commands).
- PAYLOAD: bytes are data regardless of value (header/trailer values not special). For 0x03/0x04, each byte emitted on `elem_*`; matrix row-major: col increments, wraps N-1 -> 0 with row+1. For 0x01, byte held in a pending register. Counter reaching 0 -> CHK/END.
- END: byte == `END_BYTE` -> commit: 0x01 writes `mat_size` if payload in 1..MAX_N else `frame_err`; 0x04 pulses `start`; 0x03 no pulse. Byte != `END_BYTE` -> `frame_err`, no commit. Always -> IDLE.
- Elements of a frame later rejected at END are already emitted; MxV only acts on `start`.
- Timeout: counter cleared on every `rx_done` and in IDLE; reaching `TIMEOUT_CYCLES` outside IDLE -> `frame_err`, IDLE. If `rx_done` coincides with expiry, the byte is processed and timeout is discarded.
- Reset mid-frame: FSM to IDLE, all counters and pending data cleared, `mat_size` to 0.

## Timing
- Reset values: `mat_size`=0, `elem_data`=0, `elem_valid`=0, `elem_sel`=0, `elem_row`=0, `elem_col`=0, `start`=0, `frame_err`=0, `busy`=0.
- All outputs registered. `elem_valid` high exactly the cycle after the payload byte's `rx_done`.
- `start`, `frame_err`, and `mat_size` update the cycle after the deciding byte's `rx_done` (or the timeout expiry cycle +1).
- `start` and `frame_err` never both high in one cycle.
- Back-to-back `rx_done` on consecutive cycles supported; no backpressure toward UART or from MxV.

## Configuration
- `PKT_CHECKSUM_EN` defined: CHK state inserted after PAYLOAD; expected byte = XOR of L, CMD and all payload bytes. Mismatch -> `frame_err`, IDLE, no commit. L excludes the checksum byte.
- Undefined: no CHK state; byte after payload must be `END_BYTE`.

## Test plan
- FE 02 01 03 EF -> `mat_size`=3 one cycle after EF; `frame_err`=0, no `elem_valid`.
- N=2; FE 05 03 0A 0B 0C 0D EF -> four `elem_valid` strobes: (0,0)=0A, (0,1)=0B, (1,0)=0C, (1,1)=0D, `elem_sel`=0; no `start`.
- N=2; FE 03 04 FE EF EF -> two vector elements FE (row0), EF (row1), `elem_sel`=1; `start` pulse after final EF.
- N=2; FE 04 04 01 02 03 EF (L mismatch) -> `frame_err` after CMD byte; remaining bytes ignored in IDLE; `mat_size` stays 2.
- FE 02 01 09 EF (N>MAX_N) -> `frame_err`, `mat_size` unchanged; FE 02 then silence `TIMEOUT_CYCLES` -> `frame_err`, `busy`=0.
- Assert `rst` during PAYLOAD of a vector frame -> all outputs 0 same cycle, `mat_size`=0; subsequent valid size frame accepted normally.
